// File: rtl/lane_fifo.sv
`default_nettype none
// ============================================================================
// lane_fifo : per-lane synchronous FIFO behind the 1:2 demux (clk_2f domain)
// Rev 1.0   : initial release
// ============================================================================
module lane_fifo #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH      = 2,
  parameter int unsigned ALMOST_FULL_TH  = 3,
  parameter int unsigned ALMOST_EMPTY_TH = 1
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int unsigned            DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]    C_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]    C_AF_TH   = ALMOST_FULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]    C_AE_TH   = ALMOST_EMPTY_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0]  C_PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]    C_CNT_ONE = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  err_overflow_q, err_overflow_d;
  logic                  err_underflow_q, err_underflow_d;

  logic w_full;
  logic w_empty;
  logic w_pop_ok;
  logic w_wr_en;

  // Flags decode the registered count only, so they lag the moving edge by one.
  assign w_full   = (count_q == C_DEPTH);
  assign w_empty  = (count_q == '0);
  assign w_pop_ok = pop && !w_empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign w_wr_en  = push && (!w_full || w_pop_ok);

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    data_out_d      = data_out_q;
    valid_out_d     = 1'b0;
    err_overflow_d  = err_overflow_q;
    err_underflow_d = err_underflow_q;

    if (w_wr_en) begin
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    end
    if (w_pop_ok) begin
      rd_ptr_d    = rd_ptr_q + C_PTR_ONE;
      data_out_d  = mem_q[rd_ptr_q];
      valid_out_d = 1'b1;
    end

    case ({w_wr_en, w_pop_ok})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase

    if (push && !w_wr_en) begin
      err_overflow_d = 1'b1;
    end
    if (pop && w_empty) begin
      err_underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      data_out_q      <= '0;
      valid_out_q     <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      data_out_q      <= data_out_d;
      valid_out_q     <= valid_out_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_2f) begin
    if (!reset && w_wr_en) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out      = data_out_q;
  assign valid_out     = valid_out_q;
  assign full          = w_full;
  assign empty         = w_empty;
  assign almost_full   = (count_q >= C_AF_TH);
  assign almost_empty  = (count_q <= C_AE_TH);
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

endmodule
`default_nettype wire

// File: doc/lane_fifo.md
Name: lane_fifo

Overview:
- Synchronous FIFO on each demux output lane (lane 0 and lane 1 each get one instance).
- Absorbs bursts from the 1:2 demux at clk_2f and holds them until the downstream lane consumer pops.
- Provides full/empty, almost-full/almost-empty flags for flow control, plus sticky overflow/underflow error bits.

Parameters:
DATA_WIDTH, 8, width of each stored word (matches demux output bus)
ADDR_WIDTH, 2, log2 of depth; DEPTH = 2**ADDR_WIDTH = 4
ALMOST_FULL_TH, 3, almost_full asserted when count >= this value
ALMOST_EMPTY_TH, 1, almost_empty asserted when count <= this value

Ports:
clk_2f  in  1  sole clock, same clock as the demux
reset  in  1  synchronous, active-high reset, sampled on posedge clk_2f
data_in  in  DATA_WIDTH  write data (driven by data_demux_N)
push  in  1  write request (driven by valid_demux_N)
pop  in  1  read request from downstream consumer
data_out  out  DATA_WIDTH  registered read data
valid_out  out  1  data_out holds a word popped on the previous cycle
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= ALMOST_FULL_TH
almost_empty  out  1  count <= ALMOST_EMPTY_TH
err_overflow  out  1  sticky: a push was dropped
err_underflow  out  1  sticky: a pop occurred while empty

Behaviour:
- Interface fixed: one clock, clk_2f; reset is synchronous and active-high, named reset.
- All state updates on posedge clk_2f. When reset is high at an edge, all of the following hold after that edge:
  - wr_ptr, rd_ptr and count = 0
  - data_out = 0, valid_out = 0
  - err_overflow = 0, err_underflow = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - Memory contents are not cleared.
- Reset wins over push/pop in the same cycle. Asserting reset mid-burst discards all stored words; the next accepted push lands at address 0.
- Storage: DEPTH x DATA_WIDTH register array. Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0. count is ADDR_WIDTH+1 bits.
- Write accepted (wr_en) = push && (!full || pop_ok). On wr_en, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read accepted (pop_ok) = pop && !empty. On pop_ok, data_out <= mem[rd_ptr], rd_ptr increments, and valid_out <= 1; otherwise valid_out <= 0 and data_out holds its value.
- Read latency: pop at edge n, data_out/valid_out visible after edge n+1. There is no fall-through.
- count update:
  - +1 on wr_en only
  - -1 on pop_ok only
  - unchanged when both or neither occur
- Status flags are combinational decodes of the registered count, so they change in the cycle immediately after the edge that moved count.
- Boundary cases:
  - Full, push without pop: word dropped, pointers and count unchanged, err_overflow <= 1.
  - Full, push with pop: both accepted, count stays DEPTH, no error.
  - Empty, pop (with or without push): pop ignored, err_underflow <= 1, valid_out = 0. A simultaneous push is accepted (count becomes 1) and is readable on a later pop.
  - Error bits stay set until reset.
- Ordering: strict FIFO; words come out in push order across pointer wrap.

Test Plan:
- Reset check: hold reset 2 cycles with push=1, data_in=8'hAA -> after the release edge, empty=1, almost_empty=1, full=0, valid_out=0, data_out=0, both error bits 0, and no word stored.
- Fill/drain: push 8'h01..8'h04 on 4 consecutive cycles, then pop 4 cycles:
  - almost_full rises after the 3rd push; full rises after the 4th.
  - data_out shows 01, 02, 03, 04 with valid_out=1, each one cycle after its pop.
  - empty=1 after the last pop.
- Overflow: with FIFO full (01..04), push 8'hFF alone -> err_overflow=1, count stays 4, and a later drain yields 01..04 with no FF.
- Simultaneous push+pop at full: FIFO full, push 8'h05 with pop -> data_out=01 next cycle, full stays 1; a subsequent drain yields 02, 03, 04, 05 (confirms pointer wrap).
- Underflow: from reset, assert pop and push=1 with data_in=8'h10 in the same cycle -> err_underflow=1, valid_out=0, count=1; the next pop returns 8'h10.
- Reset mid-burst: after pushing 8'h21, 8'h22, assert reset one cycle -> empty=1, both errors cleared; then push 8'h30 and pop -> data_out=8'h30.
